ir_fetch: RTL and testbench
===========================

Name: ir_fetch

Overview:
- Instruction-fetch and instruction-register stage. It sits directly upstream of the control FSM.
- On the controller's ir_load request it fetches the 64-bit eBPF instruction at the current PC from instruction memory using a req/ack handshake.
- For BPF_LDDW (0x18) it fetches the second slot as well and assembles the 64-bit immediate.
- It presents the decoded fields, op/dst/src/off/imm/imm64, qualified by ir_valid.

Parameters:
- ADDR_W, 16, instruction-memory word address width (one word = one 64-bit slot).
- INSN_W, 64, instruction slot width; fixed at 64, must not be overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ir_load  in  1  fetch request from the controller; sampled only in IDLE or DONE.
- pc_valid  in  1  pc is stable and may be used as a fetch address.
- pc  in  ADDR_W  current program counter (slot index).
- imem_req  out  1  memory read request.
- imem_addr  out  ADDR_W  memory read address.
- imem_ack  in  1  memory returns data this cycle.
- imem_data  in  64  memory read data, little-endian eBPF slot.
- op  out  8  opcode, bits [7:0] of slot 1.
- dst  out  4  destination register, bits [11:8].
- src  out  4  source register, bits [15:12].
- off  out  16  signed offset, bits [31:16].
- imm  out  32  immediate, bits [63:32].
- imm64  out  64  LDDW immediate {slot2[63:32], slot1[63:32]}; for other opcodes, sign-extended imm.
- ir_valid  out  1  all field outputs hold a complete instruction.
- ir_busy  out  1  fetch in progress.
- lddw_wide  out  1  the current instruction occupied two slots; the PC stage must advance by 2.
- fault  out  1  sticky fetch fault.

Behaviour:
- Reset (asynchronous): state IDLE; imem_req=0; imem_addr=0; every field output, imm64, ir_valid, ir_busy, lddw_wide and fault are 0. Reset mid-fetch abandons the transaction immediately. A late imem_ack after reset is ignored.
- States: IDLE, FETCH1, FETCH2, DONE, FAULT.
- IDLE / DONE:
  - If ir_load=1 and pc_valid=1: latch imem_addr<=pc, assert imem_req, go to FETCH1.
  - On that same edge ir_valid<=0 and ir_busy<=1.
  - ir_load without pc_valid is ignored.
- FETCH1:
  - imem_req and imem_addr are held stable until imem_ack.
  - On req&&ack, capture op/dst/src/off/imm.
  - If imem_data[7:0]==0x18:
    - If pc is all-ones, go to FAULT (no second slot exists).
    - Otherwise imem_addr<=pc+1, keep req high, go to FETCH2.
  - If the opcode is not 0x18: imem_req<=0, imm64<=sign-extended imm, lddw_wide<=0, go to DONE.
- FETCH2:
  - On ack, check the second slot: bits [31:0] must be 0.
  - If the check passes: imm64<={data[63:32], imm}, lddw_wide<=1, go to DONE.
  - If the check fails: go to FAULT.
  - imem_req drops on the ack edge.
- DONE: ir_valid=1, ir_busy=0. Fields hold until the next accepted ir_load.
- FAULT:
  - fault=1, ir_valid=0, imem_req=0, ir_busy=0.
  - ir_load is ignored; only rst exits FAULT.
- Field outputs change only on capture edges. Between captures they hold their previous values.
- ir_load arriving while in FETCH1 or FETCH2 is dropped; it is not queued.
- Latency, with ack in the same cycle as req:
  - Accept edge N, data captured at edge N+1, ir_valid high after edge N+1.
  - LDDW completes one cycle later per slot.
  - Each wait cycle on imem_ack adds one cycle.
- imem_addr arithmetic is modulo 2^ADDR_W. The pc all-ones LDDW case is a fault, not a wrap.

Decomposition:
- Shared include/package:
  - Opcode constants, shared with the controller; BPF_LDDW is reused.
  - Field bit-position constants: OP_LSB=0, DST_LSB=8, SRC_LSB=12, OFF_LSB=16, IMM_LSB=32.
  - State encoding constants; 3-bit encoding is sufficient.
- One natural sub-module: ir_split, a purely combinational slot-to-field splitter. The FSM uses it for the opcode check and for field capture.

Test Plan:
- Single fetch, zero wait: pc=5, ir_load=1, mem[5]=0x0000002A_00000107 (ADD_IMM r1,42), ack same cycle -> op=0x07, dst=1, imm=0x2A, imm64=0x2A, ir_valid high after 2 edges, lddw_wide=0.
- Wait states: ack delayed 3 cycles -> imem_req and imem_addr stable throughout; ir_valid asserts exactly 1 edge after ack; ir_busy high for 4 cycles.
- LDDW: mem[10]=0x89ABCDEF_00000318, mem[11]=0x01234567_00000000 -> imem_addr 10 then 11, imm64=0x0123456789ABCDEF, dst=3, lddw_wide=1.
- LDDW faults:
  - Second slot 0x...00000005 -> fault=1, ir_valid=0; a later ir_load is ignored until rst.
  - LDDW at pc=0xFFFF -> fault=1 with no second request issued.
- Boundary events:
  - ir_load pulsed during FETCH1 -> no extra fetch.
  - Negative imm 0xFFFFFFF0 on a non-LDDW opcode -> imm64=0xFFFFFFFFFFFFFFF0.
  - rst asserted mid-FETCH2 -> all outputs 0 asynchronously; a subsequent ack is ignored; a normal fetch succeeds afterwards.

Source files
------------

// File: rtl/ir_fetch_pkg.sv
// ir_fetch_pkg: shared opcode, field-position and state constants for the fetch stage
package ir_fetch_pkg;
  localparam logic [7:0] BPF_LDDW = 8'h18;
  localparam int OP_LSB  = 0;
  localparam int DST_LSB = 8;
  localparam int SRC_LSB = 12;
  localparam int OFF_LSB = 16;
  localparam int IMM_LSB = 32;
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH1 = 3'd1;
  localparam logic [2:0] S_FETCH2 = 3'd2;
  localparam logic [2:0] S_DONE   = 3'd3;
  localparam logic [2:0] S_FAULT  = 3'd4;
  function automatic logic [63:0] sext_imm(input logic [31:0] i);
    return {{32{i[31]}}, i};
  endfunction
endpackage

// File: rtl/ir_fetch_split.sv
// ir_split: combinational split of one eBPF slot into its instruction fields
module ir_split
  import ir_fetch_pkg::*;
(
  input  logic [63:0] slot,
  output logic [7:0]  op,
  output logic [3:0]  dst,
  output logic [3:0]  src,
  output logic [15:0] off,
  output logic [31:0] imm,
  output logic        is_lddw
);
  assign op      = slot[OP_LSB +: 8];
  assign dst     = slot[DST_LSB +: 4];
  assign src     = slot[SRC_LSB +: 4];
  assign off     = slot[OFF_LSB +: 16];
  assign imm     = slot[IMM_LSB +: 32];
  assign is_lddw = op == BPF_LDDW;
endmodule

// File: rtl/ir_fetch.sv
// ir_fetch: fetches one or two instruction slots over req/ack and holds the decoded instruction
module ir_fetch
  import ir_fetch_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int INSN_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ir_load,
  input  logic              pc_valid,
  input  logic [ADDR_W-1:0] pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [INSN_W-1:0] imem_data,
  output logic [7:0]        op,
  output logic [3:0]        dst,
  output logic [3:0]        src,
  output logic [15:0]       off,
  output logic [31:0]       imm,
  output logic [63:0]       imm64,
  output logic              ir_valid,
  output logic              ir_busy,
  output logic              lddw_wide,
  output logic              fault
);
  logic [2:0]  state;
  logic [7:0]  s_op;
  logic [3:0]  s_dst;
  logic [3:0]  s_src;
  logic [15:0] s_off;
  logic [31:0] s_imm;
  logic        s_lddw;

  ir_split u_split (
    .slot    (imem_data),
    .op      (s_op),
    .dst     (s_dst),
    .src     (s_src),
    .off     (s_off),
    .imm     (s_imm),
    .is_lddw (s_lddw)
  );

  // Fetch FSM: accept a load, walk one or two slots, land in DONE or the sticky FAULT state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      imem_req  <= 1'b0;
      imem_addr <= '0;
      op        <= '0;
      dst       <= '0;
      src       <= '0;
      off       <= '0;
      imm       <= '0;
      imm64     <= '0;
      ir_valid  <= 1'b0;
      ir_busy   <= 1'b0;
      lddw_wide <= 1'b0;
      fault     <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (ir_load && pc_valid) begin
          imem_addr <= pc;
          imem_req  <= 1'b1;
          ir_valid  <= 1'b0;
          ir_busy   <= 1'b1;
          state     <= S_FETCH1;
        end
        S_FETCH1: if (imem_ack) begin
          op  <= s_op;
          dst <= s_dst;
          src <= s_src;
          off <= s_off;
          imm <= s_imm;
          if (s_lddw && imem_addr == '1) begin
            imem_req <= 1'b0;
            ir_busy  <= 1'b0;
            fault    <= 1'b1;
            state    <= S_FAULT;
          end else if (s_lddw) begin
            imem_addr <= imem_addr + ADDR_W'(1);
            state     <= S_FETCH2;
          end else begin
            imem_req  <= 1'b0;
            imm64     <= sext_imm(s_imm);
            lddw_wide <= 1'b0;
            ir_valid  <= 1'b1;
            ir_busy   <= 1'b0;
            state     <= S_DONE;
          end
        end
        S_FETCH2: if (imem_ack) begin
          imem_req <= 1'b0;
          ir_busy  <= 1'b0;
          if (imem_data[31:0] == 32'd0) begin
            imm64     <= {s_imm, imm};
            lddw_wide <= 1'b1;
            ir_valid  <= 1'b1;
            state     <= S_DONE;
          end else begin
            fault <= 1'b1;
            state <= S_FAULT;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ir_fetch.sv
// tb_ir_fetch: randomized and directed checks of ir_fetch against a slot-level reference model
module tb_ir_fetch;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ir_load = 1'b0;
  logic        pc_valid = 1'b0;
  logic [15:0] pc = '0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [63:0] imem_data = '0;
  logic [7:0]  op;
  logic [3:0]  dst;
  logic [3:0]  src;
  logic [15:0] off;
  logic [31:0] imm;
  logic [63:0] imm64;
  logic        ir_valid;
  logic        ir_busy;
  logic        lddw_wide;
  logic        fault;

  ir_fetch dut (
    .clk       (clk),
    .rst       (rst),
    .ir_load   (ir_load),
    .pc_valid  (pc_valid),
    .pc        (pc),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_data (imem_data),
    .op        (op),
    .dst       (dst),
    .src       (src),
    .off       (off),
    .imm       (imm),
    .imm64     (imm64),
    .ir_valid  (ir_valid),
    .ir_busy   (ir_busy),
    .lddw_wide (lddw_wide),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  logic [63:0] mem [0:65535];
  int          wait_n = 0;
  bit          force_ack = 1'b0;
  int          cnt = 0;
  logic [15:0] acq[$];
  int          stab_err = 0;
  logic        prev_req = 1'b0;
  logic        prev_ack = 1'b0;
  logic [15:0] prev_addr = '0;

  initial forever begin
    @(negedge clk);
    if (prev_req && imem_req && !prev_ack && imem_addr !== prev_addr) stab_err++;
    prev_req  = imem_req;
    prev_addr = imem_addr;
    if (force_ack) begin
      imem_ack  = 1'b1;
      imem_data = 64'h01234567_00000000;
    end else if (imem_req && cnt >= wait_n) begin
      imem_ack  = 1'b1;
      imem_data = mem[imem_addr];
      acq.push_back(imem_addr);
      cnt = 0;
    end else begin
      imem_ack = 1'b0;
      cnt = imem_req ? cnt + 1 : 0;
    end
    prev_ack = imem_ack;
  end

  typedef struct {
    bit          flt;
    bit          wide;
    int          slots;
    logic [7:0]  op;
    logic [3:0]  dst;
    logic [3:0]  src;
    logic [15:0] off;
    logic [31:0] imm;
    logic [63:0] imm64;
  } exp_t;

  function automatic exp_t model(input logic [15:0] p);
    exp_t e;
    logic [63:0] s1 = mem[p];
    logic [63:0] s2;
    e.op = s1[7:0];
    e.dst = s1[11:8];
    e.src = s1[15:12];
    e.off = s1[31:16];
    e.imm = s1[63:32];
    e.flt = 1'b0;
    e.wide = 1'b0;
    e.slots = 1;
    e.imm64 = {{32{s1[63]}}, s1[63:32]};
    if (e.op == 8'h18) begin
      if (p == 16'hFFFF) e.flt = 1'b1;
      else begin
        s2 = mem[p + 16'd1];
        e.slots = 2;
        if (s2[31:0] != 32'd0) e.flt = 1'b1;
        else begin
          e.imm64 = {s2[63:32], s1[63:32]};
          e.wide = 1'b1;
        end
      end
    end
    return e;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_fetch(input logic [15:0] p, input int w, input bit pulse);
    exp_t e = model(p);
    int cyc = 0;
    int bcnt = 0;
    bit done = 1'b0;
    wait_n = w;
    acq.delete();
    @(negedge clk);
    pc = p;
    pc_valid = 1'b1;
    ir_load = 1'b1;
    for (int c = 1; c <= 60 && !done; c++) begin
      @(negedge clk);
      cyc = c;
      if (c == 1) begin
        ir_load = 1'b0;
        pc_valid = 1'b0;
        pc = 16'($urandom);
      end
      if (pulse && c == 2) begin
        ir_load = 1'b1;
        pc_valid = 1'b1;
        pc = p + 16'd100;
      end
      if (pulse && c == 3) ir_load = 1'b0;
      if (ir_busy) bcnt++;
      if (ir_valid || fault) done = 1'b1;
    end
    if (!done) chk("timeout", 64'(done), 64'd1);
    chk("latency", 64'(cyc), 64'(1 + e.slots * (w + 1)));
    chk("busy_cycles", 64'(bcnt), 64'(e.slots * (w + 1)));
    chk("fault", 64'(fault), 64'(e.flt));
    chk("ir_valid", 64'(ir_valid), 64'(!e.flt));
    chk("ir_busy_end", 64'(ir_busy), 64'd0);
    chk("op", 64'(op), 64'(e.op));
    chk("n_slots", 64'(acq.size()), 64'(e.slots));
    if (acq.size() > 0) chk("addr1", 64'(acq[0]), 64'(p));
    if (acq.size() > 1) chk("addr2", 64'(acq[1]), 64'(p + 16'd1));
    if (!e.flt) begin
      chk("fields", {dst, src, off, imm, 8'h00}, {e.dst, e.src, e.off, e.imm, 8'h00});
      chk("imm64", imm64, e.imm64);
      chk("lddw_wide", 64'(lddw_wide), 64'(e.wide));
    end
    @(negedge clk);
    chk("req_idle", 64'(imem_req), 64'd0);
  endtask

  initial begin
    logic [15:0] p;
    logic [7:0]  o;
    logic [63:0] s1;
    logic [31:0] lo;
    int          w;
    repeat (2) @(negedge clk);
    chk("rst_fields", {op, dst, src, off, imm}, 64'd0);
    chk("rst_imm64", imm64, 64'd0);
    chk("rst_ctl", 64'({imem_req, imem_addr, ir_valid, ir_busy, lddw_wide, fault}), 64'd0);
    rst = 1'b0;

    mem[5] = 64'h0000002A_00000107;
    do_fetch(16'd5, 0, 1'b0);
    chk("add_imm64", imm64, 64'h2A);
    mem[7] = 64'h00000011_00000207;
    do_fetch(16'd7, 3, 1'b0);
    mem[10] = 64'h89ABCDEF_00000318;
    mem[11] = 64'h01234567_00000000;
    do_fetch(16'd10, 0, 1'b0);
    chk("lddw_imm64", imm64, 64'h01234567_89ABCDEF);
    chk("lddw_dst", 64'(dst), 64'd3);
    mem[20] = 64'hFFFFFFF0_00000207;
    do_fetch(16'd20, 1, 1'b0);
    chk("neg_imm64", imm64, 64'hFFFFFFFF_FFFFFFF0);
    mem[25] = 64'h00000009_000001B7;
    do_fetch(16'd25, 3, 1'b1);

    mem[30] = 64'h11111111_00000118;
    mem[31] = 64'h22222222_00000005;
    do_fetch(16'd30, 0, 1'b0);
    acq.delete();
    @(negedge clk);
    ir_load = 1'b1;
    pc_valid = 1'b1;
    pc = 16'd5;
    repeat (4) @(negedge clk);
    ir_load = 1'b0;
    pc_valid = 1'b0;
    chk("fault_ignore_req", 64'(acq.size()), 64'd0);
    chk("fault_sticky", 64'({fault, ir_valid, ir_busy, imem_req}), 64'b1000);
    do_reset();
    chk("fault_cleared", 64'(fault), 64'd0);

    mem[16'hFFFF] = 64'h33333333_00000118;
    do_fetch(16'hFFFF, 2, 1'b0);
    repeat (3) @(negedge clk);
    chk("ffff_no_second", 64'(acq.size()), 64'd1);
    do_reset();

    mem[40] = 64'hAAAAAAAA_00000218;
    mem[41] = 64'hBBBBBBBB_00000000;
    wait_n = 3;
    acq.delete();
    @(negedge clk);
    pc = 16'd40;
    pc_valid = 1'b1;
    ir_load = 1'b1;
    @(negedge clk);
    ir_load = 1'b0;
    pc_valid = 1'b0;
    for (int c = 0; c < 20 && acq.size() == 0; c++) @(negedge clk);
    @(negedge clk);
    chk("f2_req", 64'({imem_req, imem_addr}), 64'({1'b1, 16'd41}));
    #1 rst = 1'b1;
    #1;
    chk("async_fields", {op, dst, src, off, imm}, 64'd0);
    chk("async_ctl", 64'({imem_req, imem_addr, ir_valid, ir_busy, lddw_wide, fault}), 64'd0);
    chk("async_imm64", imm64, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    force_ack = 1'b1;
    @(posedge clk);
    force_ack = 1'b0;
    @(negedge clk);
    chk("late_ack", 64'({imem_req, ir_valid, ir_busy, lddw_wide, fault}), 64'd0);
    chk("late_ack_imm64", imm64, 64'd0);
    do_fetch(16'd5, 0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      p = (i % 10 == 9) ? 16'hFFFF : 16'($urandom_range(0, 65534));
      o = ($urandom_range(0, 9) < 4) ? 8'h18 : 8'($urandom);
      if (o == 8'h18 && p != 16'hFFFF && i % 3 == 0) o = 8'h07;
      s1 = {32'($urandom), 16'($urandom), 8'($urandom), o};
      mem[p] = s1;
      if (o == 8'h18 && p != 16'hFFFF) begin
        lo = ($urandom_range(0, 4) == 0) ? (32'($urandom) | 32'd1) : 32'd0;
        mem[p + 16'd1] = {32'($urandom), lo};
      end
      w = $urandom_range(0, 3);
      do_fetch(p, w, 1'b0);
      if (fault) do_reset();
    end

    chk("addr_stable", 64'(stab_err), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
